// File: rtl/gw2a_pll_pkg.sv
// Shared state encoding and sizing helpers for the rPLL lock sequencer.
package gw2a_pll_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_READY  = 3'd3,
    ST_FAULT  = 3'd4
  } pll_state_t;

  localparam int RETRY_W = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; latency 2 cycles.
// No backpressure: the input is sampled every cycle.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic meta;
  (* ASYNC_REG = "TRUE" *) logic sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

endmodule

// File: rtl/gw2a_pll_ctrl.sv
// rPLL reset/lock sequencer with bounded retry; outputs registered, change on the transition edge.
// No backpressure: relock_i is a one-cycle request honoured immediately.
module gw2a_pll_ctrl
  import gw2a_pll_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 27000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       relock_i,
  input  logic       pll_lock_i,
  output logic       pll_reset_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic       lost_o,
  output logic [3:0] retries_o
);

  localparam int CMAX   = max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CWIDTH = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CWIDTH-1:0]  RC_LAST = CWIDTH'(RESET_CYCLES - 1);
  localparam logic [CWIDTH-1:0]  LT_LAST = CWIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [CWIDTH-1:0]  SC_LAST = CWIDTH'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] MAX_R   = RETRY_W'(MAX_RETRIES);

  pll_state_t         state;
  logic [CWIDTH-1:0]  cnt;
  logic [RETRY_W-1:0] retries;
  logic               lock_s;
  logic               retry_evt;

  sync_2ff u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d     (pll_lock_i),
    .q     (lock_s)
  );

  // A lock timeout in WAIT and any low lock_s cycle in STABLE are both failed attempts.
  assign retry_evt = !lock_s &&
                     (((state == ST_WAIT) && (cnt == LT_LAST)) || (state == ST_STABLE));

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_RESET;
      cnt         <= '0;
      retries     <= '0;
      pll_reset_o <= 1'b1;
      ready_o     <= 1'b0;
      fault_o     <= 1'b0;
      lost_o      <= 1'b0;
    end else if (relock_i) begin
      state       <= ST_RESET;
      cnt         <= '0;
      retries     <= '0;
      pll_reset_o <= 1'b1;
      ready_o     <= 1'b0;
      fault_o     <= 1'b0;
    end else if (retry_evt) begin
      cnt         <= '0;
      pll_reset_o <= 1'b1;
      if (retries == MAX_R) begin
        state   <= ST_FAULT;
        fault_o <= 1'b1;
      end else begin
        state   <= ST_RESET;
        retries <= (retries == '1) ? retries : retries + 1'b1;
      end
    end else begin
      case (state)
        ST_RESET: begin
          if (cnt == RC_LAST) begin
            state       <= ST_WAIT;
            cnt         <= '0;
            pll_reset_o <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (lock_s) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STABLE: begin
          if (cnt == SC_LAST) begin
            state   <= ST_READY;
            cnt     <= '0;
            ready_o <= 1'b1;
            retries <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_READY: begin
          if (!lock_s) begin
            state       <= ST_RESET;
            cnt         <= '0;
            retries     <= '0;
            lost_o      <= 1'b1;
            ready_o     <= 1'b0;
            pll_reset_o <= 1'b1;
          end
        end
        ST_FAULT: ;
        default: begin
          state       <= ST_RESET;
          cnt         <= '0;
          pll_reset_o <= 1'b1;
          ready_o     <= 1'b0;
          fault_o     <= 1'b0;
        end
      endcase
    end
  end

  assign retries_o = retries;

endmodule

// File: tb/tb_gw2a_pll_ctrl.sv
// Scenario bench for gw2a_pll_ctrl: event cycles are queued when stimulus is driven
// and popped when the DUT output transitions.
module tb_gw2a_pll_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       relock_i = 1'b0;
  logic       pll_lock_i = 1'b0;
  logic       pll_reset_o, ready_o, fault_o, lost_o;
  logic [3:0] retries_o;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_bad  = 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;
  exp_t sb[$];

  gw2a_pll_ctrl #(
    .RESET_CYCLES (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .relock_i   (relock_i),
    .pll_lock_i (pll_lock_i),
    .pll_reset_o(pll_reset_o),
    .ready_o    (ready_o),
    .fault_o    (fault_o),
    .lost_o     (lost_o),
    .retries_o  (retries_o)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic pick(input int sel);
    case (sel)
      0:       return pll_reset_o;
      1:       return ready_o;
      default: return fault_o;
    endcase
  endfunction

  // Returns the cycle at which the selected output first shows val, or -1 on timeout.
  task automatic wait_level(input int sel, input logic val, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (pick(sel) === val) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset    = 1'b1;
    relock_i = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    pll_lock_i = 1'b0;
    apply_reset();
    n_cmp++; if (pll_reset_o !== 1'b1) begin n_bad++; $display("FAIL rst_pll_reset: got %b want 1", pll_reset_o); end
    n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", ready_o); end
    n_cmp++; if (fault_o !== 1'b0) begin n_bad++; $display("FAIL rst_fault: got %b want 0", fault_o); end
    n_cmp++; if (lost_o !== 1'b0) begin n_bad++; $display("FAIL rst_lost: got %b want 0", lost_o); end
    n_cmp++; if (retries_o !== 4'd0) begin n_bad++; $display("FAIL rst_retries: got %0d want 0", retries_o); end
  endtask

  task automatic test_nominal();
    int   k0, at;
    exp_t e;
    reset = 1'b0;
    k0    = cyc;
    sb.push_back('{"nom_reset_fall", k0 + 4});
    wait_level(0, 1'b0, 50, at);
    e = sb.pop_front();
    n_cmp++; if (at !== e.val) begin n_bad++; $display("FAIL %s: got cycle %0d want %0d", e.tag, at, e.val); end
    repeat (10) @(negedge clock);
    pll_lock_i = 1'b1;
    sb.push_back('{"nom_ready_rise", cyc + 11});
    wait_level(1, 1'b1, 100, at);
    e = sb.pop_front();
    n_cmp++; if (at !== e.val) begin n_bad++; $display("FAIL %s: got cycle %0d want %0d", e.tag, at, e.val); end
    n_cmp++; if (retries_o !== 4'd0) begin n_bad++; $display("FAIL nom_retries: got %0d want 0", retries_o); end
    n_cmp++; if (lost_o !== 1'b0) begin n_bad++; $display("FAIL nom_lost: got %b want 0", lost_o); end
    n_cmp++; if (pll_reset_o !== 1'b0) begin n_bad++; $display("FAIL nom_pll_reset: got %b want 0", pll_reset_o); end
  endtask

  task automatic test_loss_in_ready();
    int   d, at;
    logic lost_drop;
    exp_t e;
    @(negedge clock);
    pll_lock_i = 1'b0;
    d = cyc;
    sb.push_back('{"loss_ready_fall", d + 3});
    wait_level(1, 1'b0, 20, at);
    e = sb.pop_front();
    n_cmp++; if (at !== e.val) begin n_bad++; $display("FAIL %s: got cycle %0d want %0d", e.tag, at, e.val); end
    n_cmp++; if (lost_o !== 1'b1) begin n_bad++; $display("FAIL loss_lost_set: got %b want 1", lost_o); end
    n_cmp++; if (pll_reset_o !== 1'b1) begin n_bad++; $display("FAIL loss_pll_reset: got %b want 1", pll_reset_o); end
    pll_lock_i = 1'b1;
    sb.push_back('{"loss_reacquire_ready", d + 16});
    lost_drop = 1'b0;
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (lost_o !== 1'b1) lost_drop = 1'b1;
      if (ready_o === 1'b1) begin
        at = cyc;
        break;
      end
    end
    e = sb.pop_front();
    n_cmp++; if (at !== e.val) begin n_bad++; $display("FAIL %s: got cycle %0d want %0d", e.tag, at, e.val); end
    n_cmp++; if (lost_drop !== 1'b0) begin n_bad++; $display("FAIL loss_lost_sticky: got drop=%b want 0", lost_drop); end
    n_cmp++; if (retries_o !== 4'd0) begin n_bad++; $display("FAIL loss_retries: got %0d want 0", retries_o); end
  endtask

  task automatic test_glitch();
    int   k0, at;
    exp_t e;
    pll_lock_i = 1'b0;
    apply_reset();
    reset = 1'b0;
    k0    = cyc;
    repeat (6) @(negedge clock);
    pll_lock_i = 1'b1;
    repeat (6) @(negedge clock);
    pll_lock_i = 1'b0;
    @(negedge clock);
    pll_lock_i = 1'b1;
    sb.push_back('{"glitch_reset_rise", k0 + 15});
    wait_level(0, 1'b1, 20, at);
    e = sb.pop_front();
    n_cmp++; if (at !== e.val) begin n_bad++; $display("FAIL %s: got cycle %0d want %0d", e.tag, at, e.val); end
    n_cmp++; if (retries_o !== 4'd1) begin n_bad++; $display("FAIL glitch_retries: got %0d want 1", retries_o); end
    n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL glitch_ready_low: got %b want 0", ready_o); end
    sb.push_back('{"glitch_retry_ready", k0 + 28});
    wait_level(1, 1'b1, 60, at);
    e = sb.pop_front();
    n_cmp++; if (at !== e.val) begin n_bad++; $display("FAIL %s: got cycle %0d want %0d", e.tag, at, e.val); end
    n_cmp++; if (retries_o !== 4'd0) begin n_bad++; $display("FAIL glitch_retries_clr: got %0d want 0", retries_o); end
  endtask

  task automatic test_no_lock();
    int   k0, at;
    logic held;
    exp_t e;
    pll_lock_i = 1'b0;
    apply_reset();
    reset = 1'b0;
    k0    = cyc;
    for (int a = 0; a < 3; a++) begin
      sb.push_back('{"nolock_reset_fall", k0 + 4 + 24 * a});
      wait_level(0, 1'b0, 60, at);
      e = sb.pop_front();
      n_cmp++; if (at !== e.val) begin n_bad++; $display("FAIL %s[%0d]: got cycle %0d want %0d", e.tag, a, at, e.val); end
      n_cmp++; if (retries_o !== 4'(a)) begin n_bad++; $display("FAIL nolock_retries_wait[%0d]: got %0d want %0d", a, retries_o, a); end
      sb.push_back('{"nolock_reset_rise", k0 + 24 + 24 * a});
      wait_level(0, 1'b1, 60, at);
      e = sb.pop_front();
      n_cmp++; if (at !== e.val) begin n_bad++; $display("FAIL %s[%0d]: got cycle %0d want %0d", e.tag, a, at, e.val); end
      n_cmp++; if (fault_o !== (a == 2)) begin n_bad++; $display("FAIL nolock_fault[%0d]: got %b want %b", a, fault_o, (a == 2)); end
    end
    held = 1'b1;
    repeat (50) begin
      @(negedge clock);
      if (fault_o !== 1'b1 || pll_reset_o !== 1'b1 || retries_o !== 4'd2) held = 1'b0;
    end
    n_cmp++; if (held !== 1'b1) begin n_bad++; $display("FAIL nolock_fault_held: got %b want 1", held); end
  endtask

  task automatic test_relock();
    int   at;
    exp_t e;
    @(negedge clock);
    pll_lock_i = 1'b1;
    repeat (4) @(negedge clock);
    relock_i = 1'b1;
    sb.push_back('{"relock_reset_fall", cyc + 5});
    sb.push_back('{"relock_ready", cyc + 14});
    @(negedge clock);
    relock_i = 1'b0;
    n_cmp++; if (fault_o !== 1'b0) begin n_bad++; $display("FAIL relock_fault_clr: got %b want 0", fault_o); end
    n_cmp++; if (pll_reset_o !== 1'b1) begin n_bad++; $display("FAIL relock_pll_reset: got %b want 1", pll_reset_o); end
    n_cmp++; if (retries_o !== 4'd0) begin n_bad++; $display("FAIL relock_retries: got %0d want 0", retries_o); end
    wait_level(0, 1'b0, 20, at);
    e = sb.pop_front();
    n_cmp++; if (at !== e.val) begin n_bad++; $display("FAIL %s: got cycle %0d want %0d", e.tag, at, e.val); end
    wait_level(1, 1'b1, 40, at);
    e = sb.pop_front();
    n_cmp++; if (at !== e.val) begin n_bad++; $display("FAIL %s: got cycle %0d want %0d", e.tag, at, e.val); end
    @(negedge clock);
    relock_i = 1'b1;
    sb.push_back('{"relock_ready_again", cyc + 14});
    @(negedge clock);
    relock_i = 1'b0;
    n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL relock_ready_drop: got %b want 0", ready_o); end
    wait_level(1, 1'b1, 40, at);
    e = sb.pop_front();
    n_cmp++; if (at !== e.val) begin n_bad++; $display("FAIL %s: got cycle %0d want %0d", e.tag, at, e.val); end
  endtask

  task automatic test_mid_reset();
    int at;
    @(negedge clock);
    pll_lock_i = 1'b0;
    wait_level(1, 1'b0, 10, at);
    pll_lock_i = 1'b1;
    repeat (6) @(negedge clock);
    n_cmp++; if (lost_o !== 1'b1) begin n_bad++; $display("FAIL mid_pre_lost: got %b want 1", lost_o); end
    n_cmp++; if (pll_reset_o !== 1'b0) begin n_bad++; $display("FAIL mid_pre_pll_reset: got %b want 0", pll_reset_o); end
    reset = 1'b1;
    @(negedge clock);
    n_cmp++; if (pll_reset_o !== 1'b1) begin n_bad++; $display("FAIL mid_pll_reset: got %b want 1", pll_reset_o); end
    n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL mid_ready: got %b want 0", ready_o); end
    n_cmp++; if (fault_o !== 1'b0) begin n_bad++; $display("FAIL mid_fault: got %b want 0", fault_o); end
    n_cmp++; if (lost_o !== 1'b0) begin n_bad++; $display("FAIL mid_lost: got %b want 0", lost_o); end
    n_cmp++; if (retries_o !== 4'd0) begin n_bad++; $display("FAIL mid_retries: got %0d want 0", retries_o); end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_loss_in_ready();
    test_glitch();
    test_no_lock();
    test_relock();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
